timer_avalon_master: RTL
========================

# timer_avalon_master

Avalon-MM master that programs and services the 16-bit interval timer slave (6-register map: status, control, period_l, period_h, snap_l, snap_h) without a CPU. A host-side command port starts a one-shot or continuous timeout. The block clears the timer's `irq` on every timeout, emits a one-cycle tick and keeps a timeout count. It sits beside the timer in the DE0-CV system as the hardware-only alternative to a Nios driver.

## Interface
Parameters:
- `CNT_W`, 16: width of the `timeout_count` output.

Ports:
- `clk`  in  1: system clock. The block has one clock.
- `reset_n`  in  1: asynchronous, active-low reset.
- `cmd_start`  in  1: start pulse. Sampled only in IDLE.
- `cmd_period`  in  32: timer period, written as 16-bit low and high halves.
- `cmd_continuous`  in  1: 1 selects auto-reload, 0 selects one-shot.
- `cmd_stop`  in  1: stop pulse, accepted in any non-IDLE state.
- `busy`  out  1: high whenever the FSM is not IDLE.
- `tick`  out  1: one-cycle pulse per serviced timeout.
- `timeout_count`  out  CNT_W: number of serviced timeouts, wraps modulo 2^CNT_W.
- `snapshot`  out  32: counter value captured at the last timeout (see Configuration).
- `address`  out  3: timer register index.
- `chipselect`  out  1: timer select.
- `write_n`  out  1: active-low write strobe.
- `writedata`  out  16: timer write data.
- `readdata`  in  16: timer read data, registered by the slave, valid one cycle after `address`.
- `irq`  in  1: level interrupt from the timer.

## Operation
FSM states: IDLE, CLR0, WR_PL, WR_PH, WR_CTRL, RUN, CLR_ST, WR_STOP. SNAP_WR, SNAP_RL, SNAP_RH and SNAP_DONE exist only with the Configuration macro.

Bus cycles issued per state:
- Every non-IDLE state except RUN drives exactly one bus cycle with `chipselect`=1.
- Writes drive `write_n`=0. Read states drive `write_n`=1.
- IDLE and RUN drive `chipselect`=0, `write_n`=1, `address`=0, `writedata`=0.

Start sequence:
- IDLE + `cmd_start`: latch `cmd_period` and `cmd_continuous`, go to CLR0.
- CLR0: write addr 0, data 0. This clears a stale timeout.
- WR_PL: write addr 2, data `period[15:0]`.
- WR_PH: write addr 3, data `period[31:16]`.
- WR_CTRL: write addr 1, data `{12'b0, 1'b0, 1'b1, cont, 1'b1}`. This gives 0x0007 for continuous and 0x0005 for one-shot, i.e. START=1 with interrupt enable.
- The FSM then enters RUN.

Servicing and stop:
- RUN + `irq`=1: go to CLR_ST, which writes addr 0, data 0.
- On leaving CLR_ST, pulse `tick` and increment `timeout_count`.
- After CLR_ST: if continuous, return to RUN; if one-shot, go to IDLE.
- `cmd_stop` in RUN: go to WR_STOP, which writes addr 1, data 0x0008 (STOP, interrupt disabled), then go to IDLE.

Boundary rules:
- `cmd_stop` during CLR0..WR_CTRL or CLR_ST sets `stop_pend`. The pending stop is taken instead of entering or returning to RUN. `stop_pend` clears in IDLE.
- `cmd_stop` and `irq` in the same RUN cycle: stop wins. The timeout is not counted. WR_STOP does not clear status.
- `cmd_start` while `busy`: ignored.
- `cmd_start` and `cmd_stop` together in IDLE: start is taken, stop is ignored.
- `cmd_period`=0 is legal. The timer times out immediately, and the block services it normally.
- Reset mid-operation: FSM goes to IDLE and every output returns to its reset value. Any partial timer programming is abandoned.

## Timing
- Reset values: `busy`=0, `tick`=0, `timeout_count`=0, `snapshot`=0, `chipselect`=0, `write_n`=1, `address`=0, `writedata`=0.
- All outputs are registered.
- Start latency: `cmd_start` sampled at edge 0. Bus writes occur in cycles 1-4 (CLR0, WR_PL, WR_PH, WR_CTRL). RUN begins in cycle 5.
- Writes are back-to-back, one per cycle, with no wait states.
- `irq` sampled high at edge k puts CLR_ST in cycle k+1. `tick` is high in cycle k+2, when `irq` is already low.
- Minimum continuous period serviced without a miss: 3 cycles without snapshot, 7 cycles with snapshot.

## Configuration
- Macro: `TIMER_AVALON_MASTER_SNAPSHOT_EN`.

Defined:
- After CLR_ST, the FSM runs SNAP_WR (write addr 4, data 0), then SNAP_RL (read addr 4).
- SNAP_RH reads addr 5 and captures `readdata` as `snapshot[15:0]` at the end of that cycle.
- SNAP_DONE captures `readdata` as `snapshot[31:16]`.
- `tick` and the count increment move to the cycle after SNAP_DONE.
- The snapshot states honour `stop_pend` like CLR_ST does.

Undefined:
- The four snapshot states are absent.
- `snapshot` is tied to 0.

## Test plan
- Reset, then `cmd_start` with period 0x0002_2E97, continuous: bus writes in order are (0,0x0000), (2,0x2E97), (3,0x0002), (1,0x0007) in cycles 1-4, and `busy`=1.
- Continuous period 99: over 1000 cycles `timeout_count`=10, with one `tick` per `irq` rising edge and one addr-0 write per `tick`.
- One-shot period 50: exactly one `tick`, `busy` drops to 0 one cycle after CLR_ST, and no further bus activity.
- `cmd_stop` asserted during WR_PH: sequence completes through WR_CTRL, then write (1,0x0008), then IDLE, with `timeout_count` unchanged.
- `cmd_stop` coincident with `irq` in RUN: write (1,0x0008), no `tick`, and no addr-0 write.
- With `TIMER_AVALON_MASTER_SNAPSHOT_EN`: the slave model returns 0x1234 for addr 4 and 0xABCD for addr 5, and `snapshot`=0xABCD1234 in the `tick` cycle.

Source files
------------

// File: rtl/timer_avalon_master.sv
// Avalon-MM master that programs a 16-bit interval timer, clears its timeouts and counts them.
// Define TIMER_AVALON_MASTER_SNAPSHOT_EN to also read the timer snapshot on every timeout.
module timer_avalon_master #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cmd_start,
    input  logic [31:0]      cmd_period,
    input  logic             cmd_continuous,
    input  logic             cmd_stop,
    output logic             busy,
    output logic             tick,
    output logic [CNT_W-1:0] timeout_count,
    output logic [31:0]      snapshot,
    output logic [2:0]       address,
    output logic             chipselect,
    output logic             write_n,
    output logic [15:0]      writedata,
    input  logic [15:0]      readdata,
    input  logic             irq
);

    localparam logic [2:0]  REG_STATUS   = 3'd0;
    localparam logic [2:0]  REG_CONTROL  = 3'd1;
    localparam logic [2:0]  REG_PERIOD_L = 3'd2;
    localparam logic [2:0]  REG_PERIOD_H = 3'd3;
    localparam logic [2:0]  REG_SNAP_L   = 3'd4;
    localparam logic [2:0]  REG_SNAP_H   = 3'd5;
    localparam logic [15:0] CTRL_STOP    = 16'h0008;

    typedef enum logic [3:0] {
        IDLE,
        CLR0,
        WR_PL,
        WR_PH,
        WR_CTRL,
        RUN,
        CLR_ST,
        WR_STOP
`ifdef TIMER_AVALON_MASTER_SNAPSHOT_EN
        ,
        SNAP_WR,
        SNAP_RL,
        SNAP_RH,
        SNAP_DONE
`endif
    } state_t;

    state_t           state_reg;
    state_t           state_next;
    state_t           resume_state;
    logic [31:0]      period_reg;
    logic             cont_reg;
    logic             stop_pend_reg;
    logic             stop_pend_next;
    logic             stop_now;
    logic             serviced;
    logic             busy_reg;
    logic             tick_reg;
    logic [CNT_W-1:0] count_reg;
    logic             chipselect_reg;
    logic             write_n_reg;
    logic [2:0]       address_reg;
    logic [15:0]      writedata_reg;
    logic             chipselect_next;
    logic             write_n_next;
    logic [2:0]       address_next;
    logic [15:0]      writedata_next;

    assign stop_now = stop_pend_reg | cmd_stop;

    // A fully serviced timeout either ends a one-shot, honours a pending stop, or keeps running.
    always_comb begin
        if (!cont_reg) begin
            resume_state = IDLE;
        end else if (stop_now) begin
            resume_state = WR_STOP;
        end else begin
            resume_state = RUN;
        end
    end

    always_comb begin
        state_next     = state_reg;
        stop_pend_next = stop_pend_reg;
        serviced       = 1'b0;
        case (state_reg)
            IDLE: begin
                stop_pend_next = 1'b0;
                if (cmd_start) begin
                    state_next = CLR0;
                end
            end
            CLR0: begin
                stop_pend_next = stop_now;
                state_next     = WR_PL;
            end
            WR_PL: begin
                stop_pend_next = stop_now;
                state_next     = WR_PH;
            end
            WR_PH: begin
                stop_pend_next = stop_now;
                state_next     = WR_CTRL;
            end
            WR_CTRL: begin
                stop_pend_next = stop_now;
                state_next     = stop_now ? WR_STOP : RUN;
            end
            RUN: begin
                // Stop beats a coincident timeout; that timeout is left uncounted.
                if (cmd_stop) begin
                    state_next = WR_STOP;
                end else if (irq) begin
                    state_next = CLR_ST;
                end
            end
            CLR_ST: begin
                stop_pend_next = stop_now;
`ifdef TIMER_AVALON_MASTER_SNAPSHOT_EN
                state_next     = SNAP_WR;
`else
                serviced       = 1'b1;
                state_next     = resume_state;
`endif
            end
            WR_STOP: begin
                state_next = IDLE;
            end
`ifdef TIMER_AVALON_MASTER_SNAPSHOT_EN
            SNAP_WR: begin
                stop_pend_next = stop_now;
                state_next     = SNAP_RL;
            end
            SNAP_RL: begin
                stop_pend_next = stop_now;
                state_next     = SNAP_RH;
            end
            SNAP_RH: begin
                stop_pend_next = stop_now;
                state_next     = SNAP_DONE;
            end
            SNAP_DONE: begin
                stop_pend_next = stop_now;
                serviced       = 1'b1;
                state_next     = resume_state;
            end
`endif
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Bus signals are decoded from the state being entered so they are registered with it.
    always_comb begin
        chipselect_next = 1'b0;
        write_n_next    = 1'b1;
        address_next    = 3'd0;
        writedata_next  = 16'h0000;
        case (state_next)
            CLR0, CLR_ST: begin
                chipselect_next = 1'b1;
                write_n_next    = 1'b0;
                address_next    = REG_STATUS;
            end
            WR_PL: begin
                chipselect_next = 1'b1;
                write_n_next    = 1'b0;
                address_next    = REG_PERIOD_L;
                writedata_next  = period_reg[15:0];
            end
            WR_PH: begin
                chipselect_next = 1'b1;
                write_n_next    = 1'b0;
                address_next    = REG_PERIOD_H;
                writedata_next  = period_reg[31:16];
            end
            WR_CTRL: begin
                chipselect_next = 1'b1;
                write_n_next    = 1'b0;
                address_next    = REG_CONTROL;
                writedata_next  = {12'b0, 1'b0, 1'b1, cont_reg, 1'b1};
            end
            WR_STOP: begin
                chipselect_next = 1'b1;
                write_n_next    = 1'b0;
                address_next    = REG_CONTROL;
                writedata_next  = CTRL_STOP;
            end
`ifdef TIMER_AVALON_MASTER_SNAPSHOT_EN
            SNAP_WR: begin
                chipselect_next = 1'b1;
                write_n_next    = 1'b0;
                address_next    = REG_SNAP_L;
            end
            SNAP_RL: begin
                chipselect_next = 1'b1;
                address_next    = REG_SNAP_L;
            end
            SNAP_RH, SNAP_DONE: begin
                chipselect_next = 1'b1;
                address_next    = REG_SNAP_H;
            end
`endif
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= IDLE;
            period_reg     <= 32'h0;
            cont_reg       <= 1'b0;
            stop_pend_reg  <= 1'b0;
            busy_reg       <= 1'b0;
            tick_reg       <= 1'b0;
            count_reg      <= '0;
            chipselect_reg <= 1'b0;
            write_n_reg    <= 1'b1;
            address_reg    <= 3'd0;
            writedata_reg  <= 16'h0000;
        end else begin
            state_reg     <= state_next;
            stop_pend_reg <= stop_pend_next;
            if (state_reg == IDLE && cmd_start) begin
                period_reg <= cmd_period;
                cont_reg   <= cmd_continuous;
            end
            busy_reg <= (state_next != IDLE);
            tick_reg <= serviced;
            if (serviced) begin
                count_reg <= count_reg + CNT_W'(1);
            end
            chipselect_reg <= chipselect_next;
            write_n_reg    <= write_n_next;
            address_reg    <= address_next;
            writedata_reg  <= writedata_next;
        end
    end

`ifdef TIMER_AVALON_MASTER_SNAPSHOT_EN
    logic [31:0] snapshot_reg;

    // readdata lags the address by one cycle: snap_l lands during SNAP_RH, snap_h during SNAP_DONE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            snapshot_reg <= 32'h0;
        end else begin
            if (state_reg == SNAP_RH) begin
                snapshot_reg[15:0] <= readdata;
            end
            if (state_reg == SNAP_DONE) begin
                snapshot_reg[31:16] <= readdata;
            end
        end
    end

    assign snapshot = snapshot_reg;
`else
    logic unused_readdata;
    assign unused_readdata = ^readdata;
    assign snapshot        = 32'h0;
`endif

    assign busy          = busy_reg;
    assign tick          = tick_reg;
    assign timeout_count = count_reg;
    assign chipselect    = chipselect_reg;
    assign write_n       = write_n_reg;
    assign address       = address_reg;
    assign writedata     = writedata_reg;

endmodule
